// File: rtl/prf_free_list_alloc_pkg.sv
// Shared sizing defaults and FSM state type for the PRF free-list allocator.
`ifndef N
`define N 3
`endif
`ifndef PRF_NUM_ENTRIES
`define PRF_NUM_ENTRIES 64
`endif
`ifndef PRF_NUM_INDEX_BITS
`define PRF_NUM_INDEX_BITS 6
`endif
`ifndef RAT_SIZE
`define RAT_SIZE 32
`endif

package prf_free_list_alloc_pkg;

    localparam int unsigned FlSlots      = `N;
    localparam int unsigned FlPrfEntries = `PRF_NUM_ENTRIES;
    localparam int unsigned FlIdxW       = `PRF_NUM_INDEX_BITS;
    localparam int unsigned FlArchRegs   = `RAT_SIZE;

    // RUN allocates normally; RECOVER is the single dead cycle after a nuke reload.
    typedef enum logic [0:0] {
        StRun     = 1'b0,
        StRecover = 1'b1
    } fl_state_e;

endpackage

// File: rtl/free_list_psel.sv
// One stage of the allocation chain: picks the lowest set bit of the candidate
// vector when enabled and hands the vector, with that bit removed, to the next stage.
module free_list_psel #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned IDX_W   = 6
) (
    input  logic               en_i,
    input  logic [ENTRIES-1:0] cand_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic [ENTRIES-1:0] cand_o
);

    // Lowest-index search; scanning downward lets the last hit win.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (en_i && cand_i[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
        cand_o = cand_i;
        if (found_o) begin
            cand_o[idx_o] = 1'b0;
        end
    end

endmodule

// File: rtl/prf_free_list_alloc.sv
// Physical register free list with N-wide zero-latency allocation, retire frees
// and nuke recovery from the RRAT free vector.
// Optional feature: define FREE_LIST_BYPASS_EN to make same-cycle frees grantable.
module prf_free_list_alloc
    import prf_free_list_alloc_pkg::*;
#(
    parameter int unsigned N           = FlSlots,
    parameter int unsigned PRF_ENTRIES = FlPrfEntries,
    parameter int unsigned ARCH_REGS   = FlArchRegs,
    parameter int unsigned IDX_W       = FlIdxW
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      nuke,
    input  logic [PRF_ENTRIES-1:0]    restore_free,
    input  logic [PRF_ENTRIES-1:0]    free_vec,
    input  logic [N-1:0]              req,
    output logic [N-1:0][IDX_W-1:0]   grant_idx,
    output logic [N-1:0]              grant_valid,
    output logic                      stall,
    output logic [PRF_ENTRIES-1:0]    free_list,
    output logic [IDX_W:0]            free_count
);

    // Entries above the architectural set start free; entry 0 is never free.
    localparam logic [PRF_ENTRIES-1:0] ResetFree =
        ~((PRF_ENTRIES'(1) << ARCH_REGS) - PRF_ENTRIES'(1)) & ~PRF_ENTRIES'(1);

    fl_state_e                state_q, state_d;
    logic [PRF_ENTRIES-1:0]   free_q, free_d;
    logic [PRF_ENTRIES-1:0]   avail;
    logic [PRF_ENTRIES-1:0]   grant_mask;
    logic [PRF_ENTRIES-1:0]   cand [N+1];
    logic [N-1:0]             found;
    logic [N-1:0][IDX_W-1:0]  sel_idx;
    logic [IDX_W:0]           avail_count, req_count, free_cnt;
    logic                     grant_en;

    // Candidate vector for allocation, optionally including this cycle's frees.
    always_comb begin
        avail = free_q;
`ifdef FREE_LIST_BYPASS_EN
        avail = avail | free_vec;
`endif
        avail[0] = 1'b0;
    end

    // Population counts for the all-or-nothing check and the free_count output.
    always_comb begin
        avail_count = '0;
        free_cnt    = '0;
        req_count   = '0;
        for (int i = 0; i < PRF_ENTRIES; i++) begin
            avail_count = avail_count + (IDX_W+1)'(avail[i]);
            free_cnt    = free_cnt + (IDX_W+1)'(free_q[i]);
        end
        for (int k = 0; k < N; k++) begin
            req_count = req_count + (IDX_W+1)'(req[k]);
        end
    end

    assign cand[0] = avail;

    for (genvar k = 0; k < N; k++) begin : g_slot
        free_list_psel #(
            .ENTRIES (PRF_ENTRIES),
            .IDX_W   (IDX_W)
        ) u_psel (
            .en_i    (req[k]),
            .cand_i  (cand[k]),
            .found_o (found[k]),
            .idx_o   (sel_idx[k]),
            .cand_o  (cand[k+1])
        );
    end

    // Grants only in RUN, never during a nuke, and only if every request fits.
    always_comb begin
        grant_en = (state_q == StRun) && !nuke && (req_count <= avail_count);
        stall    = (|req) && !grant_en;
        for (int k = 0; k < N; k++) begin
            grant_valid[k] = found[k] && grant_en;
            grant_idx[k]   = grant_valid[k] ? sel_idx[k] : '0;
        end
        // Bits the chain consumed are exactly the granted entries.
        grant_mask = grant_en ? (cand[0] & ~cand[N]) : '0;
    end

    // Next free vector and state; grants win over a same-cycle free of the same entry.
    always_comb begin
        if (nuke) begin
            free_d  = restore_free;
            state_d = StRecover;
        end else begin
            free_d  = (free_q | free_vec) & ~grant_mask;
            state_d = StRun;
        end
        free_d[0] = 1'b0;
    end

    // State registers; reset aborts any allocation in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            free_q  <= ResetFree;
            state_q <= StRun;
        end else begin
            free_q  <= free_d;
            state_q <= state_d;
        end
    end

    assign free_list  = free_q;
    assign free_count = free_cnt;

endmodule

// File: tb/tb_prf_free_list_alloc.sv
// Scoreboard bench for prf_free_list_alloc: the driver queues hand-computed
// expectations, the monitor pops and compares them against the DUT outputs.
module tb_prf_free_list_alloc;

    localparam logic [63:0] RstPat = 64'hFFFF_FFFF_0000_0000;

    logic              clock;
    logic              reset_n;
    logic              nuke;
    logic [63:0]       restore_free;
    logic [63:0]       free_vec;
    logic [2:0]        req;
    logic [2:0][5:0]   grant_idx;
    logic [2:0]        grant_valid;
    logic              stall;
    logic [63:0]       free_list;
    logic [6:0]        free_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string           nm;
        logic [2:0]      gv;
        logic [2:0][5:0] gi;
        logic            st;
        logic [6:0]      fc;
        logic            cl;
        logic [63:0]     fl;
    } exp_t;

    exp_t sb[$];
    event chk_ev;

    prf_free_list_alloc u_dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .nuke         (nuke),
        .restore_free (restore_free),
        .free_vec     (free_vec),
        .req          (req),
        .grant_idx    (grant_idx),
        .grant_valid  (grant_valid),
        .stall        (stall),
        .free_list    (free_list),
        .free_count   (free_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input logic [2:0] egv, input logic [5:0] e0,
                        input logic [5:0] e1, input logic [5:0] e2, input logic est,
                        input logic [6:0] efc, input logic cl, input logic [63:0] el);
        exp_t e;
        e.nm = nm;
        e.gv = egv;
        e.gi = {e2, e1, e0};
        e.st = est;
        e.fc = efc;
        e.cl = cl;
        e.fl = el;
        sb.push_back(e);
    endtask

    task automatic step(input string nm, input logic [2:0] rq, input logic nk,
                        input logic [63:0] rs, input logic [63:0] fv,
                        input logic [2:0] egv, input logic [5:0] e0, input logic [5:0] e1,
                        input logic [5:0] e2, input logic est, input logic [6:0] efc,
                        input logic cl, input logic [63:0] el);
        @(posedge clock);
        #1;
        req          = rq;
        nuke         = nk;
        restore_free = rs;
        free_vec     = fv;
        push(nm, egv, e0, e1, e2, est, efc, cl, el);
    endtask

    // Monitor: compare every queued expectation at the falling edge or on demand.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock or chk_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.nm, ".grant_valid"}, 64'(grant_valid), 64'(e.gv));
                chk({e.nm, ".grant_idx"}, 64'(grant_idx), 64'(e.gi));
                chk({e.nm, ".stall"}, 64'(stall), 64'(e.st));
                chk({e.nm, ".free_count"}, 64'(free_count), 64'(e.fc));
                if (e.cl) chk({e.nm, ".free_list"}, free_list, e.fl);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Driver: directed vectors with hand-computed expectations.
    initial begin
        reset_n      = 1'b0;
        nuke         = 1'b0;
        restore_free = '0;
        free_vec     = '0;
        req          = '0;
        step("rst", 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 0, 7'd32, 1, RstPat);
        @(negedge clock);
        #1 reset_n = 1'b1;
        step("idle0", 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 0, 7'd32, 1, RstPat);
        step("alloc3", 3'b111, 0, 0, 0, 3'b111, 6'd32, 6'd33, 6'd34, 0, 7'd32, 0, 0);
        step("after3", 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 0, 7'd29, 1, 64'hFFFF_FFF8_0000_0000);
        step("alloc1", 3'b001, 0, 0, 0, 3'b001, 6'd35, 0, 0, 0, 7'd29, 0, 0);
        step("nuke", 3'b111, 1, RstPat, 0, 3'b000, 0, 0, 0, 1, 7'd28, 0, 0);
        step("recover", 3'b010, 0, 0, 0, 3'b000, 0, 0, 0, 1, 7'd32, 1, RstPat);
        step("run_again", 3'b010, 0, 0, 0, 3'b010, 0, 6'd32, 0, 0, 7'd32, 0, 0);
        step("nuke2", 3'b000, 1, 64'h0000_0300_0000_0000, 0, 3'b000, 0, 0, 0, 0, 7'd31, 0, 0);
        step("nuke_in_rec", 3'b001, 1, 64'h0000_0300_0000_0000, 0,
             3'b000, 0, 0, 0, 1, 7'd2, 0, 0);
        step("rec_noreq", 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 0, 7'd2, 1, 64'h0000_0300_0000_0000);
        step("too_many", 3'b111, 0, 0, 0, 3'b000, 0, 0, 0, 1, 7'd2, 0, 0);
        step("sparse", 3'b101, 0, 0, 0, 3'b101, 6'd40, 0, 6'd41, 0, 7'd2, 1,
             64'h0000_0300_0000_0000);
        step("empty", 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 0, 7'd0, 1, 64'h0);
`ifdef FREE_LIST_BYPASS_EN
        step("free50", 3'b001, 0, 0, 64'h0004_0000_0000_0000, 3'b001, 6'd50, 0, 0, 0, 7'd0, 0, 0);
        step("free50_next", 3'b001, 0, 0, 0, 3'b000, 0, 0, 0, 1, 7'd0, 1, 64'h0);
`else
        step("free50", 3'b001, 0, 0, 64'h0004_0000_0000_0000, 3'b000, 0, 0, 0, 1, 7'd0, 0, 0);
        step("free50_next", 3'b001, 0, 0, 0, 3'b001, 6'd50, 0, 0, 0, 7'd1, 0, 0);
`endif
        step("free60_61", 3'b000, 0, 0, 64'h3000_0000_0000_0000,
             3'b000, 0, 0, 0, 0, 7'd0, 1, 64'h0);
        step("grant_and_free", 3'b001, 0, 0, 64'h1000_0000_0000_0000,
             3'b001, 6'd60, 0, 0, 0, 7'd2, 1, 64'h3000_0000_0000_0000);
        step("free_bit0", 3'b000, 0, 0, 64'h1, 3'b000, 0, 0, 0, 0, 7'd1, 1,
             64'h2000_0000_0000_0000);
        step("bit0_stays", 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 0, 7'd1, 1,
             64'h2000_0000_0000_0000);
        step("inflight", 3'b001, 0, 0, 0, 3'b001, 6'd61, 0, 0, 0, 7'd1, 0, 0);
        // Assert reset between edges and check before any rising edge occurs.
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        push("async_rst", 3'b001, 6'd32, 0, 0, 0, 7'd32, 1, RstPat);
        ->chk_ev;
        #0.5 req = 3'b000;
        #0.5 reset_n = 1'b1;
        step("post_rst", 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 0, 7'd32, 1, RstPat);
        step("realloc", 3'b111, 0, 0, 0, 3'b111, 6'd32, 6'd33, 6'd34, 0, 7'd32, 0, 0);
        @(negedge clock);
        #1;
        chk("queue_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
